// File: rtl/cpu_mul_sequencer_if.sv
// Request/response and multiply-cell bundle for cpu_mul_sequencer.
interface cpu_mul_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_src1;
    logic [31:0] req_src2;
    logic [31:0] mul_src1;
    logic [31:0] mul_src2;
    logic [31:0] mul_cell_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;

    modport slave (
        input  req_valid, req_op, req_src1, req_src2,
        input  mul_cell_result, rsp_ready,
        output req_ready, mul_src1, mul_src2,
        output rsp_valid, rsp_result
    );

    modport master (
        output req_valid, req_op, req_src1, req_src2,
        output mul_cell_result, rsp_ready,
        input  req_ready, mul_src1, mul_src2,
        input  rsp_valid, rsp_result
    );
endinterface

// File: rtl/cpu_mul_sequencer.sv
// Multi-pass 32x32 multiply controller driving a 32x16 multiply cell.
// Define CPU_MUL_SEQ_MULX_EN to enable the high-word MULX* operations.
module cpu_mul_sequencer #(
    parameter int MUL_LATENCY = 1
) (
    input logic                 clk,
    input logic                 reset,
    cpu_mul_sequencer_if.slave  bus
);

    localparam logic [1:0] OP_MUL   = 2'd0;
    localparam logic [1:0] OP_MULXSS = 2'd1;
    localparam logic [1:0] OP_MULXSU = 2'd2;
    localparam logic [1:0] WLOAD    = 2'(MUL_LATENCY - 1);

`ifdef CPU_MUL_SEQ_MULX_EN
    localparam int ACC_W = 64;
    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_CORR, S_DONE
    } state_t;
`else
    localparam int ACC_W = 32;
    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_DONE
    } state_t;
`endif

    state_t             r_state;
    logic [1:0]         r_op;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic [1:0]         r_pass;
    logic [1:0]         r_wcnt;
    logic [ACC_W-1:0]   r_acc;
    logic [31:0]        r_src1;
    logic [31:0]        r_src2;
    logic               r_req_ready;
    logic               r_rsp_valid;
    logic [31:0]        r_rsp_result;

    logic [5:0]         w_shift;
    logic [ACC_W-1:0]   w_add;
    logic [ACC_W-1:0]   w_acc_nx;
    logic [1:0]         w_last;
    logic [1:0]         w_pass_nx;

    // Operand pair {src1, src2} for a given pass of the pass table.
    function automatic logic [63:0] f_pass(
        input logic [1:0]  op,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [1:0]  p
    );
        logic [31:0] s1;
        logic [31:0] s2;
        if (op == OP_MUL) begin
            s1 = a;
            s2 = p[0] ? {16'h0, b[31:16]} : {16'h0, b[15:0]};
        end else begin
            s1 = p[0] ? {16'h0, a[31:16]} : {16'h0, a[15:0]};
            s2 = p[1] ? {16'h0, b[31:16]} : {16'h0, b[15:0]};
        end
        return {s1, s2};
    endfunction

    always_comb begin
        w_shift = 6'd0;
        if (r_op == OP_MUL) begin
            w_shift = r_pass[0] ? 6'd16 : 6'd0;
            w_last  = 2'd1;
        end else begin
            w_last = 2'd3;
            unique case (1'b1)
                (r_pass == 2'd0): w_shift = 6'd0;
                (r_pass == 2'd3): w_shift = 6'd32;
                default:          w_shift = 6'd16;
            endcase
        end
    end

    assign w_add     = ACC_W'(bus.mul_cell_result) << w_shift;
    assign w_acc_nx  = r_acc + w_add;
    assign w_pass_nx = r_pass + 2'd1;

`ifdef CPU_MUL_SEQ_MULX_EN
    logic [31:0] w_hi;
    logic [31:0] w_c1;
    logic [31:0] w_c2;
    logic [31:0] w_corr;

    // Unsigned product to signed: subtract the sign-weighted cross terms.
    assign w_hi   = r_acc[63:32];
    assign w_c1   = ((r_op == OP_MULXSS || r_op == OP_MULXSU) && r_a[31])
                    ? r_b : 32'h0;
    assign w_c2   = (r_op == OP_MULXSS && r_b[31]) ? r_a : 32'h0;
    assign w_corr = w_hi - w_c1 - w_c2;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_op         <= 2'd0;
            r_a          <= 32'h0;
            r_b          <= 32'h0;
            r_pass       <= 2'd0;
            r_wcnt       <= 2'd0;
            r_acc        <= '0;
            r_src1       <= 32'h0;
            r_src2       <= 32'h0;
            r_req_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= 32'h0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_op        <= bus.req_op;
                        r_a         <= bus.req_src1;
                        r_b         <= bus.req_src2;
                        r_pass      <= 2'd0;
                        r_wcnt      <= 2'd0;
                        r_acc       <= '0;
                        r_req_ready <= 1'b0;
`ifdef CPU_MUL_SEQ_MULX_EN
                        r_state <= S_ISSUE;
                        {r_src1, r_src2} <= f_pass(bus.req_op,
                            bus.req_src1, bus.req_src2, 2'd0);
`else
                        if (bus.req_op == OP_MUL) begin
                            r_state <= S_ISSUE;
                            {r_src1, r_src2} <= f_pass(bus.req_op,
                                bus.req_src1, bus.req_src2, 2'd0);
                        end else begin
                            r_state      <= S_DONE;
                            r_rsp_valid  <= 1'b1;
                            r_rsp_result <= 32'h0;
                        end
`endif
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
                    r_wcnt  <= WLOAD;
                end
                S_WAIT: begin
                    if (r_wcnt != 2'd0) begin
                        r_wcnt <= r_wcnt - 2'd1;
                    end else begin
                        r_acc <= w_acc_nx;
                        if (r_pass != w_last) begin
                            r_pass  <= w_pass_nx;
                            r_state <= S_ISSUE;
                            {r_src1, r_src2} <= f_pass(r_op, r_a, r_b,
                                                       w_pass_nx);
                        end else begin
                            r_src1 <= 32'h0;
                            r_src2 <= 32'h0;
`ifdef CPU_MUL_SEQ_MULX_EN
                            if (r_op == OP_MUL) begin
                                r_state      <= S_DONE;
                                r_rsp_valid  <= 1'b1;
                                r_rsp_result <= w_acc_nx[31:0];
                            end else begin
                                r_state <= S_CORR;
                            end
`else
                            r_state      <= S_DONE;
                            r_rsp_valid  <= 1'b1;
                            r_rsp_result <= w_acc_nx[31:0];
`endif
                        end
                    end
                end
`ifdef CPU_MUL_SEQ_MULX_EN
                S_CORR: begin
                    r_state      <= S_DONE;
                    r_rsp_valid  <= 1'b1;
                    r_rsp_result <= w_corr;
                end
`endif
                S_DONE: begin
                    if (bus.rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.mul_src1   = r_src1;
    assign bus.mul_src2   = r_src2;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_result = r_rsp_result;

endmodule
